// File: rtl/ls_crc8_serial_pkg.sv
// Shared types and constants for the serial CRC engine family.
// No logic, no latency; no flow control of its own.
// Holds the FSM state enum, default CRC-8 polynomial and bit counter width.
package ls_crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crc_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int         BIT_CNT_W = 16;

    // Saturating increment so long frames pin at all-ones instead of wrapping.
    function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
        return (&v) ? v : v + BIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ls_crc8_serial_if.sv
// Handshake and result bundle between a bit source and the serial CRC engine.
// Pure wiring, zero latency.
// Source paces bits with din_valid; engine reports ready/busy/done (crc_ok with LS_CRC8_SERIAL_CHECK_EN).
interface ls_crc8_serial_if #(
    parameter int WIDTH = 8
) ();
    import ls_crc_pkg::*;

    logic                 start;
    logic                 din_valid;
    logic                 din;
    logic                 din_last;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     crc_out;
    logic [BIT_CNT_W-1:0] bit_count;
`ifdef LS_CRC8_SERIAL_CHECK_EN
    logic                 crc_ok;

    modport master (
        output start, din_valid, din, din_last,
        input  ready, busy, done, crc_out, bit_count, crc_ok
    );
    modport slave (
        input  start, din_valid, din, din_last,
        output ready, busy, done, crc_out, bit_count, crc_ok
    );
`else
    modport master (
        output start, din_valid, din, din_last,
        input  ready, busy, done, crc_out, bit_count
    );
    modport slave (
        input  start, din_valid, din, din_last,
        output ready, busy, done, crc_out, bit_count
    );
`endif
endinterface

// File: rtl/ls_crc8_serial_step.sv
// One-bit CRC step: the XOR feedback network of an LFSR-style CRC register.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module ls_crc_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] crc,
    input  logic             din,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] crc_nxt
);
    logic fb;

    assign fb      = crc[WIDTH-1] ^ din;
    assign crc_nxt = {crc[WIDTH-2:0], 1'b0} ^ (poly & {WIDTH{fb}});

endmodule

// File: rtl/ls_crc8_serial.sv
// Bit-serial CRC engine, MSB first; optional zero-residue flag under LS_CRC8_SERIAL_CHECK_EN.
// crc_out reflects a bit one cycle after its edge; done pulses the cycle after the din_last edge.
// One bit per cycle when din_valid; start wins over din_valid and aborts any frame in flight.
module ls_crc8_serial
    import ls_crc_pkg::*;
#(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = CRC8_POLY,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic           clk,
    input  logic           rst,
    ls_crc8_serial_if.slave bus
);

    crc_state_e           state_q, state_d;
    logic [WIDTH-1:0]     crc_q, crc_d;
    logic [BIT_CNT_W-1:0] bit_count_q, bit_count_d;
    logic [WIDTH-1:0]     crc_step;
`ifdef LS_CRC8_SERIAL_CHECK_EN
    logic                 crc_ok_q, crc_ok_d;
`endif

    ls_crc_step #(.WIDTH(WIDTH)) u_step (
        .crc     (crc_q),
        .din     (bus.din),
        .poly    (POLY),
        .crc_nxt (crc_step)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        bit_count_d = bit_count_q;
`ifdef LS_CRC8_SERIAL_CHECK_EN
        crc_ok_d    = crc_ok_q;
`endif
        if (bus.start) begin
            state_d     = RUN;
            crc_d       = INIT;
            bit_count_d = '0;
`ifdef LS_CRC8_SERIAL_CHECK_EN
            crc_ok_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (bus.din_valid) begin
                        crc_d       = crc_step;
                        bit_count_d = sat_inc(bit_count_q);
                        if (bus.din_last) begin
                            state_d = DONE;
`ifdef LS_CRC8_SERIAL_CHECK_EN
                            // Flag is judged on the value being registered, so it lines up with done.
                            crc_ok_d = (crc_step == '0);
`endif
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            bit_count_q <= '0;
`ifdef LS_CRC8_SERIAL_CHECK_EN
            crc_ok_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            bit_count_q <= bit_count_d;
`ifdef LS_CRC8_SERIAL_CHECK_EN
            crc_ok_q    <= crc_ok_d;
`endif
        end
    end

    // Status flags come only from registered state.
    assign bus.ready     = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.crc_out   = crc_q;
    assign bus.bit_count = bit_count_q;
`ifdef LS_CRC8_SERIAL_CHECK_EN
    assign bus.crc_ok    = crc_ok_q;
`endif

endmodule
